// File: rtl/apu_bus_responder.sv
// apu_bus_responder: synchronous model of a memory-mapped peripheral behind the
// CPU bus pads. It decodes a 4-byte register window (DATA, CTRL, RELOAD, STATUS),
// answers CPU reads on DPads, and latches CPU writes from DPads. An 8-bit countdown
// timer ticks once per CPU cycle and raises an active-low IRQ.
module apu_bus_responder #(
    parameter logic [15:0] BASE    = 16'h4020,
    parameter int          RD_HOLD = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [15:0] APads,
    input  logic        RWPad,
    input  logic        M2Pad,
    inout  wire  [7:0]  DPads,
    output logic        n_IRQPad
);

    localparam logic [1:0] HOLD_LD = 2'(RD_HOLD);

    localparam logic [1:0] IDX_DATA   = 2'd0;
    localparam logic [1:0] IDX_CTRL   = 2'd1;
    localparam logic [1:0] IDX_RELOAD = 2'd2;
    localparam logic [1:0] IDX_STATUS = 2'd3;

    // Pad samples
    logic        m2_q;
    logic [15:0] a_q;
    logic        rw_q;
    logic [7:0]  d_q;

    // Bus cycle context, captured at the M2 rise so mid-cycle address/RW
    // changes are ignored until the next rise
    logic        cyc_hit;
    logic        cyc_rw;
    logic [1:0]  cyc_idx;

    // Read drive state
    logic        drv_r;
    logic [1:0]  hold_r;
    logic [7:0]  rd_data_r;

    // Register file and timer
    logic [7:0]  data_r;
    logic [2:0]  ctrl_r;      // {RUN, RELOAD, IEN}
    logic [7:0]  reload_r;
    logic [7:0]  cnt_r;
    logic        pending_r;
    logic        n_irq_r;

    logic        rise;
    logic        fall;
    logic        hit;
    logic [1:0]  idx;
    logic [7:0]  rd_mux;
    logic        wr_en;
    logic        tick;
    logic        underflow;

    assign rise = M2Pad & ~m2_q;
    assign fall = ~M2Pad & m2_q;
    assign hit  = (a_q[15:2] == BASE[15:2]);
    assign idx  = a_q[1:0];

    // Writes and timer ticks both happen on the M2 falling edge
    assign wr_en     = fall & cyc_hit & ~cyc_rw;
    assign tick      = fall & ctrl_r[2] & (cnt_r != 8'd0);
    assign underflow = tick & (cnt_r == 8'd1);

    assign DPads    = drv_r ? rd_data_r : 8'bz;
    assign n_IRQPad = n_irq_r;

    // Read data selection for the currently decoded register
    always_comb begin
        rd_mux = data_r;
        case (idx)
            IDX_CTRL:   rd_mux = {5'b0, ctrl_r};
            IDX_RELOAD: rd_mux = reload_r;
            IDX_STATUS: rd_mux = {pending_r, cnt_r[6:0]};
            default:    rd_mux = data_r;
        endcase
    end

    // Register the pads every clock for edge detection and decode
    always_ff @(posedge CLK) begin
        if (RES) begin
            m2_q <= 1'b0;
            a_q  <= 16'd0;
            rw_q <= 1'b0;
            d_q  <= 8'd0;
        end else begin
            m2_q <= M2Pad;
            a_q  <= APads;
            rw_q <= RWPad;
            d_q  <= DPads;
        end
    end

    // Bus cycle capture and read drive window: drive from the rise, keep
    // driving through M2 high, then RD_HOLD clocks past the fall. A new rise
    // cancels any hold and re-decodes.
    always_ff @(posedge CLK) begin
        if (RES) begin
            cyc_hit   <= 1'b0;
            cyc_rw    <= 1'b0;
            cyc_idx   <= 2'd0;
            drv_r     <= 1'b0;
            hold_r    <= 2'd0;
            rd_data_r <= 8'd0;
        end else if (rise) begin
            cyc_hit   <= hit;
            cyc_rw    <= rw_q;
            cyc_idx   <= idx;
            drv_r     <= hit & rw_q;
            rd_data_r <= rd_mux;
            hold_r    <= 2'd0;
        end else if (fall && drv_r) begin
            if (HOLD_LD == 2'd0) begin
                drv_r <= 1'b0;
            end else begin
                hold_r <= HOLD_LD;
            end
        end else if (drv_r && hold_r != 2'd0) begin
            hold_r <= hold_r - 2'd1;
            if (hold_r == 2'd1) begin
                drv_r <= 1'b0;
            end
        end
    end

    // Register writes and the countdown timer; a RELOAD write overrides the
    // tick's counter update, and an underflow wins over a STATUS clear
    always_ff @(posedge CLK) begin
        if (RES) begin
            data_r    <= 8'd0;
            ctrl_r    <= 3'd0;
            reload_r  <= 8'd0;
            cnt_r     <= 8'd0;
            pending_r <= 1'b0;
        end else begin
            if (wr_en && cyc_idx == IDX_DATA) begin
                data_r <= d_q;
            end
            if (wr_en && cyc_idx == IDX_CTRL) begin
                ctrl_r <= d_q[2:0];
            end
            if (wr_en && cyc_idx == IDX_RELOAD) begin
                reload_r <= d_q;
            end

            if (wr_en && cyc_idx == IDX_RELOAD) begin
                cnt_r <= d_q;
            end else if (underflow) begin
                cnt_r <= ctrl_r[1] ? reload_r : 8'd0;
            end else if (tick) begin
                cnt_r <= cnt_r - 8'd1;
            end

            if (underflow) begin
                pending_r <= 1'b1;
            end else if (wr_en && cyc_idx == IDX_STATUS) begin
                pending_r <= 1'b0;
            end
        end
    end

    // IRQ output, registered one clock behind pending/IEN
    always_ff @(posedge CLK) begin
        if (RES) begin
            n_irq_r <= 1'b1;
        end else begin
            n_irq_r <= ~(pending_r & ctrl_r[0]);
        end
    end

endmodule

// File: tb/tb_apu_bus_responder.sv
// Testbench for apu_bus_responder: CPU bus cycles are issued by a stimulus
// process that updates a per-CPU-cycle register model and queues expected read
// responses and IRQ transitions; a monitor pops and compares them as the DUT
// presents its outputs.
module tb_apu_bus_responder;

    localparam logic [15:0] BASE    = 16'h4020;
    localparam int          RD_HOLD = 1;

    logic        CLK;
    logic        RES;
    logic [15:0] APads;
    logic        RWPad;
    logic        M2Pad;
    wire  [7:0]  DPads;
    logic        n_IRQPad;

    logic        tb_oe;
    logic [7:0]  tb_d;

    assign DPads = tb_oe ? tb_d : 8'bz;

    apu_bus_responder #(.BASE(BASE), .RD_HOLD(RD_HOLD)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .APads    (APads),
        .RWPad    (RWPad),
        .M2Pad    (M2Pad),
        .DPads    (DPads),
        .n_IRQPad (n_IRQPad)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] val;
        int         len;
    } rd_exp_t;

    typedef struct {
        logic val;
        int   at;
    } irq_exp_t;

    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];

    // Reference model: register contents as seen between CPU cycles
    logic [7:0] m_data, m_reload, m_cnt;
    logic [2:0] m_ctrl;
    logic       m_pend;
    logic       m_irq;

    task automatic model_reset();
        m_data = 0; m_reload = 0; m_cnt = 0; m_ctrl = 0; m_pend = 0; m_irq = 1;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] i);
        case (i)
            2'd0:    return m_data;
            2'd1:    return {5'b0, m_ctrl};
            2'd2:    return m_reload;
            default: return {m_pend, m_cnt[6:0]};
        endcase
    endfunction

    // One CPU cycle's end: timer tick with the old CTRL, then the write
    task automatic model_fall(input bit hit, input bit rw, input logic [1:0] i,
                              input logic [7:0] wd);
        bit         running, und, wr;
        logic [7:0] next_cnt;
        running  = m_ctrl[2] && (m_cnt != 0);
        und      = running && (m_cnt == 1);
        next_cnt = m_cnt;
        if (und)          next_cnt = m_ctrl[1] ? m_reload : 8'd0;
        else if (running) next_cnt = m_cnt - 1;
        wr = hit && !rw;
        if (und) m_pend = 1;
        else if (wr && i == 3) m_pend = 0;
        if (wr && i == 0) m_data = wd;
        if (wr && i == 1) m_ctrl = wd[2:0];
        if (wr && i == 2) begin
            m_reload = wd;
            next_cnt = wd;
        end
        m_cnt = next_cnt;
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic note_irq(input int at);
        logic nv;
        nv = !(m_pend && m_ctrl[0]);
        if (nv != m_irq) begin
            irq_q.push_back('{val: nv, at: at});
            m_irq = nv;
        end
    endtask

    // One full CPU bus cycle: address setup, M2 high for hi clocks, low for lo clocks
    task automatic cpu_cycle(input logic [15:0] a, input bit rw, input logic [7:0] wd,
                             input int hi, input int lo);
        bit         hit;
        logic [1:0] i;
        int         f_at;
        step();
        APads = a; RWPad = rw; tb_d = wd; tb_oe = !rw;
        step();
        hit = (a[15:2] == BASE[15:2]);
        i   = a[1:0];
        M2Pad = 1'b1;
        if (hit && rw) rd_q.push_back('{val: model_read(i), len: hi + RD_HOLD});
        repeat (hi) step();
        M2Pad = 1'b0;
        f_at  = cyc + 1;
        model_fall(hit, rw, i, wd);
        note_irq(f_at + 1);
        repeat (lo) step();
        tb_oe = 1'b0;
    endtask

    // Reset asserted while a DATA read is being driven
    task automatic reset_mid_read();
        int r_at;
        step();
        APads = BASE; RWPad = 1'b1; tb_oe = 1'b0;
        step();
        M2Pad = 1'b1;
        r_at  = cyc + 1;
        rd_q.push_back('{val: model_read(2'd0), len: 2});
        step();
        step();
        RES   = 1'b1;
        M2Pad = 1'b0;
        if (m_irq == 1'b0) irq_q.push_back('{val: 1'b1, at: r_at + 2});
        model_reset();
        step();
        RES = 1'b0;
        step();
        step();
    endtask

    // Monitor: read responses, write-cycle bus integrity, IRQ transitions
    bit         mon_en = 0;
    bit         rd_active = 0;
    bit         have_exp = 0;
    int         rd_len = 0;
    logic [7:0] rd_val;
    rd_exp_t    cur;
    irq_exp_t   icur;
    logic       last_irq = 1'b1;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (tb_oe) begin
                n_checks++;
                if (DPads !== tb_d) begin
                    n_errors++;
                    $display("FAIL write_bus: DPads=%h expected %h", DPads, tb_d);
                end
            end else if (DPads !== 8'bz) begin
                if (!rd_active) begin
                    rd_active = 1; rd_len = 1; rd_val = DPads;
                    n_checks++;
                    if (rd_q.size() == 0) begin
                        have_exp = 0;
                        n_errors++;
                        $display("FAIL unexpected_drive: DPads=%h expected Z", DPads);
                    end else begin
                        cur = rd_q.pop_front();
                        have_exp = 1;
                        if (DPads !== cur.val) begin
                            n_errors++;
                            $display("FAIL read_data: DPads=%h expected %h", DPads, cur.val);
                        end
                    end
                end else begin
                    rd_len++;
                    n_checks++;
                    if (DPads !== rd_val) begin
                        n_errors++;
                        $display("FAIL read_stable: DPads=%h expected %h", DPads, rd_val);
                    end
                end
            end else if (rd_active) begin
                rd_active = 0;
                if (have_exp) begin
                    n_checks++;
                    if (rd_len != cur.len) begin
                        n_errors++;
                        $display("FAIL read_window: driven %0d clocks expected %0d", rd_len, cur.len);
                    end
                end
            end

            if (n_IRQPad !== last_irq) begin
                n_checks++;
                if (irq_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL irq_unexpected: n_IRQPad=%b at clk %0d, no change expected", n_IRQPad, cyc);
                end else begin
                    icur = irq_q.pop_front();
                    if (n_IRQPad !== icur.val || cyc != icur.at) begin
                        n_errors++;
                        $display("FAIL irq_change: n_IRQPad=%b at clk %0d expected %b at clk %0d",
                                 n_IRQPad, cyc, icur.val, icur.at);
                    end
                end
                last_irq = n_IRQPad;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          pick;
        RES = 1'b1; APads = 16'h0000; RWPad = 1'b1; M2Pad = 1'b0;
        tb_oe = 1'b0; tb_d = 8'h00;
        model_reset();
        repeat (3) step();
        RES = 1'b0;
        step();

        n_checks++;
        if (n_IRQPad !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_irq: n_IRQPad=%b expected 1", n_IRQPad);
        end
        n_checks++;
        if (DPads !== 8'bz) begin
            n_errors++;
            $display("FAIL reset_dpads: DPads=%h expected Z", DPads);
        end
        mon_en = 1;

        // Idle traffic and reads of the freshly reset window
        cpu_cycle(16'h4010, 1, 8'h00, 6, 6);
        cpu_cycle(16'h4030, 0, 8'hFF, 6, 6);
        for (int i = 0; i < 4; i++) cpu_cycle(BASE + 16'(i), 1, 8'h00, 2, 2);

        // Scratch register
        cpu_cycle(16'h4020, 0, 8'hA5, 3, 3);
        cpu_cycle(16'h4020, 1, 8'h00, 3, 3);
        cpu_cycle(16'h4024, 1, 8'h00, 3, 3);

        // One-shot timer
        cpu_cycle(16'h4022, 0, 8'h03, 2, 2);
        cpu_cycle(16'h4021, 0, 8'h05, 2, 2);
        for (int i = 0; i < 3; i++) cpu_cycle(16'h4010, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4010, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 1, 8'h00, 2, 2);

        // Auto-reload with acknowledges on non-underflow and underflow cycles
        cpu_cycle(16'h4021, 0, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 0, 8'h00, 2, 2);
        cpu_cycle(16'h4022, 0, 8'h02, 2, 2);
        cpu_cycle(16'h4021, 0, 8'h07, 2, 2);
        cpu_cycle(16'h4010, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4010, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 0, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 0, 8'h00, 2, 2);
        cpu_cycle(16'h4023, 1, 8'h00, 2, 2);

        // Mask and unmask
        cpu_cycle(16'h4021, 0, 8'h04, 2, 2);
        cpu_cycle(16'h4023, 1, 8'h00, 2, 2);
        cpu_cycle(16'h4021, 0, 8'h05, 2, 2);

        // Reset during a driven read
        cpu_cycle(16'h4020, 0, 8'h5A, 2, 2);
        reset_mid_read();
        for (int i = 0; i < 4; i++) cpu_cycle(BASE + 16'(i), 1, 8'h00, 2, 2);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 5);
            if (pick < 4)       a = BASE + 16'(pick);
            else if (pick == 4) a = BASE + 16'd4;
            else                a = 16'($urandom);
            cpu_cycle(a, bit'($urandom_range(0, 1)), 8'($urandom),
                      $urandom_range(1, 4), $urandom_range(2, 4));
        end

        repeat (6) step();
        n_checks++;
        if (rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL read_queue: %0d reads never driven, expected 0", rd_q.size());
        end
        n_checks++;
        if (irq_q.size() != 0) begin
            n_errors++;
            $display("FAIL irq_queue: %0d IRQ changes never seen, expected 0", irq_q.size());
        end
        n_checks++;
        if (n_IRQPad !== m_irq) begin
            n_errors++;
            $display("FAIL irq_final: n_IRQPad=%b expected %b", n_IRQPad, m_irq);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
